// File: rtl/rns_fwd_conv_seq_if.sv
// Valid/ready bundle for the sequential binary-to-RNS forward converter:
// operand in on one handshake, residues out on the other.
interface rns_fwd_conv_seq_if #(
    parameter int DYN_SIZE = 16,
    parameter int MAX_MOD  = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [DYN_SIZE-1:0] N;
    logic                out_valid;
    logic                out_ready;
    logic [MAX_MOD-1:0]  x0;
    logic [MAX_MOD-1:0]  x1;
    logic [MAX_MOD-1:0]  x2;
    logic [MAX_MOD-1:0]  x3;
    logic                busy;

    modport master (
        output in_valid, N, out_ready,
        input  in_ready, out_valid, x0, x1, x2, x3, busy
    );

    modport slave (
        input  in_valid, N, out_ready,
        output in_ready, out_valid, x0, x1, x2, x3, busy
    );
endinterface

// File: rtl/rns_fwd_conv_seq.sv
// Iterative binary-to-RNS converter: power-of-two residue by truncation,
// odd residues by MSB-first Horner reduction, one operand bit per clock.
module rns_fwd_conv_seq #(
    parameter int DYN_SIZE = 16,
    parameter int N_MOD    = 4,
    parameter int MOD_1_K  = 5,
    parameter int MOD_2    = 17,
    parameter int MOD_3    = 13,
    parameter int MOD_4    = 11,
    parameter int MAX_MOD  = 5
) (
    input  logic                clk,
    input  logic                reset,
    rns_fwd_conv_seq_if.slave   bus
);
    localparam int CNT_W = $clog2(DYN_SIZE);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DYN_SIZE - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]              state_reg;
    logic [1:0]              state_next;
    logic [CNT_W-1:0]        cnt_reg;
    logic [DYN_SIZE-1:0]     shift_reg;
    logic [MAX_MOD-1:0]      x0_reg;
    logic                    out_valid_reg;
    logic                    accept;
    logic                    running;
    logic                    last_bit;
    logic                    msb;
    logic [3:1][MAX_MOD-1:0] x_odd;

    assign accept   = (state_reg == ST_IDLE) && bus.in_valid;
    assign running  = (state_reg == ST_RUN);
    assign last_bit = running && (cnt_reg == CNT_LAST);
    assign msb      = shift_reg[DYN_SIZE-1];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept)        state_next = ST_RUN;
            ST_RUN:  if (last_bit)      state_next = ST_DONE;
            ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
            default:                    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            x0_reg        <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                shift_reg <= bus.N;
                cnt_reg   <= '0;
                x0_reg    <= MAX_MOD'(bus.N[MOD_1_K-1:0]);
            end else if (running) begin
                shift_reg <= shift_reg << 1;
                cnt_reg   <= cnt_reg + CNT_W'(1);
            end
            if (last_bit) begin
                out_valid_reg <= 1'b1;
            end else if ((state_reg == ST_DONE) && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    // One reduction lane per odd modulus; lanes beyond N_MOD tie off to zero.
    for (genvar gi = 1; gi <= 3; gi++) begin : g_lane
        if (gi < N_MOD) begin : g_on
            localparam int MOD_VAL = (gi == 1) ? MOD_2 : ((gi == 2) ? MOD_3 : MOD_4);
            localparam logic [MAX_MOD:0] MOD_W = (MAX_MOD + 1)'(MOD_VAL);

            logic [MAX_MOD-1:0] r_reg;
            logic [MAX_MOD-1:0] r_next;
            logic [MAX_MOD-1:0] x_reg;
            logic [MAX_MOD:0]   t;

            // r < m keeps 2r+b below 2m, so a single subtract normalises it.
            always_comb begin
                t      = {r_reg, msb};
                r_next = t[MAX_MOD-1:0];
                if (t >= MOD_W) begin
                    r_next = MAX_MOD'(t - MOD_W);
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_reg <= '0;
                    x_reg <= '0;
                end else if (accept) begin
                    r_reg <= '0;
                end else if (running) begin
                    r_reg <= r_next;
                    if (last_bit) begin
                        x_reg <= r_next;
                    end
                end
            end

            assign x_odd[gi] = x_reg;
        end else begin : g_off
            assign x_odd[gi] = '0;
        end
    end

    assign bus.in_ready  = (state_reg == ST_IDLE) && reset;
    assign bus.busy      = running;
    assign bus.out_valid = out_valid_reg;
    assign bus.x0        = x0_reg;
    assign bus.x1        = x_odd[1];
    assign bus.x2        = x_odd[2];
    assign bus.x3        = x_odd[3];
endmodule

// File: tb/tb_rns_fwd_conv_seq.sv
// Scoreboard bench for rns_fwd_conv_seq: stimulus pushes expected residues,
// a negedge monitor checks every presented result and its latency.
module tb_rns_fwd_conv_seq;
    localparam int LAT = 16;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   last_acc = 0;
    bit   seen_first = 1'b0;

    typedef struct {
        logic [15:0] n;
        logic [4:0]  e0, e1, e2, e3;
        int          acc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rns_fwd_conv_seq_if #(.DYN_SIZE(16), .MAX_MOD(5)) ifc();
    rns_fwd_conv_seq #(
        .DYN_SIZE(16), .N_MOD(4), .MOD_1_K(5), .MOD_2(17), .MOD_3(13), .MOD_4(11), .MAX_MOD(5)
    ) dut (
        .clk(clk), .reset(reset), .bus(ifc)
    );

    rns_fwd_conv_seq_if #(.DYN_SIZE(12), .MAX_MOD(3)) ifc2();
    rns_fwd_conv_seq #(
        .DYN_SIZE(12), .N_MOD(3), .MOD_1_K(3), .MOD_2(7), .MOD_3(5), .MOD_4(3), .MAX_MOD(3)
    ) dut2 (
        .clk(clk), .reset(reset), .bus(ifc2)
    );

    // Monitor: compare the head of the scoreboard on every valid cycle.
    always @(negedge clk) begin
        if (ifc.out_valid) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_output got=(%0d,%0d,%0d,%0d) required no output",
                         ifc.x0, ifc.x1, ifc.x2, ifc.x3);
            end else begin
                n_cmp++;
                if (ifc.x0 !== sb[0].e0 || ifc.x1 !== sb[0].e1 ||
                    ifc.x2 !== sb[0].e2 || ifc.x3 !== sb[0].e3) begin
                    n_bad++;
                    $display("FAIL residues N=%0d got=(%0d,%0d,%0d,%0d) required=(%0d,%0d,%0d,%0d)",
                             sb[0].n, ifc.x0, ifc.x1, ifc.x2, ifc.x3,
                             sb[0].e0, sb[0].e1, sb[0].e2, sb[0].e3);
                end
                if (!seen_first) begin
                    seen_first = 1'b1;
                    n_cmp++;
                    if (cyc - sb[0].acc != LAT) begin
                        n_bad++;
                        $display("FAIL latency N=%0d got=%0d required=%0d",
                                 sb[0].n, cyc - sb[0].acc, LAT);
                    end
                end
                if (ifc.out_ready) begin
                    $display("txn N=%0d residues=(%0d,%0d,%0d,%0d)",
                             sb[0].n, ifc.x0, ifc.x1, ifc.x2, ifc.x3);
                    void'(sb.pop_front());
                    seen_first = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [15:0] n, input bit push,
                         input logic [4:0] e0, input logic [4:0] e1,
                         input logic [4:0] e2, input logic [4:0] e3);
        int waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        while (!ifc.in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!ifc.in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL issue_timeout in_ready=%0b required 1", ifc.in_ready);
            return;
        end
        ifc.in_valid = 1'b1;
        ifc.N        = n;
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        last_acc     = cyc;
        if (push) begin
            e.n = n; e.e0 = e0; e.e1 = e1; e.e2 = e2; e.e3 = e3; e.acc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (sb.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_valid();
        int waited;
        waited = 0;
        while (!ifc.out_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time=%0t required earlier finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] n;
        int acc2;
        int waited;

        ifc.in_valid  = 1'b0;
        ifc.N         = '0;
        ifc.out_ready = 1'b1;
        ifc2.in_valid = 1'b0;
        ifc2.N        = '0;
        ifc2.out_ready = 1'b1;
        reset = 1'b1;

        // Reset held three cycles with in_valid asserted.
        @(negedge clk);
        reset = 1'b0;
        ifc.in_valid = 1'b1;
        ifc.N = 16'd1000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ifc.out_valid !== 1'b0 || ifc.in_ready !== 1'b0 || ifc.busy !== 1'b0 ||
                ifc.x0 !== 5'd0 || ifc.x1 !== 5'd0 || ifc.x2 !== 5'd0 || ifc.x3 !== 5'd0) begin
                n_bad++;
                $display("FAIL reset_state v=%0b rdy=%0b busy=%0b x=(%0d,%0d,%0d,%0d) required 0,0,0,(0,0,0,0)",
                         ifc.out_valid, ifc.in_ready, ifc.busy, ifc.x0, ifc.x1, ifc.x2, ifc.x3);
            end
        end
        ifc.in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_after_release rdy=%0b v=%0b required 1,0", ifc.in_ready, ifc.out_valid);
        end

        // Directed single conversions.
        issue(16'd0,     1, 5'd0,  5'd0,  5'd0,  5'd0);
        issue(16'd1000,  1, 5'd8,  5'd14, 5'd12, 5'd10);
        issue(16'd65535, 1, 5'd31, 5'd0,  5'd2,  5'd8);
        issue(16'd12345, 1, 5'd25, 5'd3,  5'd8,  5'd3);
        issue(16'd32768, 1, 5'd0,  5'd9,  5'd8,  5'd10);
        issue(16'd255,   1, 5'd31, 5'd0,  5'd8,  5'd2);
        drain();

        // Backpressure with ignored in_valid pulses in RUN and DONE.
        @(posedge clk); #1; ifc.out_ready = 1'b0;
        issue(16'd1000, 1, 5'd8, 5'd14, 5'd12, 5'd10);
        repeat (5) @(negedge clk);
        ifc.in_valid = 1'b1; ifc.N = 16'd5;
        @(negedge clk);
        ifc.in_valid = 1'b0;
        wait_valid();
        ifc.in_valid = 1'b1;
        repeat (2) @(negedge clk);
        ifc.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (ifc.out_valid !== 1'b1 || ifc.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL held_done v=%0b rdy=%0b required 1,0", ifc.out_valid, ifc.in_ready);
        end
        @(posedge clk); #1; ifc.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (ifc.in_ready !== 1'b1 || ifc.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL release_to_idle rdy=%0b v=%0b required 1,0", ifc.in_ready, ifc.out_valid);
        end
        drain();

        // Reset in the middle of a conversion aborts it.
        issue(16'd65535, 0, 5'd0, 5'd0, 5'd0, 5'd0);
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ifc.out_valid !== 1'b0 || ifc.busy !== 1'b0 || ifc.in_ready !== 1'b0 ||
            ifc.x0 !== 5'd0 || ifc.x1 !== 5'd0 || ifc.x2 !== 5'd0 || ifc.x3 !== 5'd0) begin
            n_bad++;
            $display("FAIL abort_reset v=%0b busy=%0b rdy=%0b x=(%0d,%0d,%0d,%0d) required 0,0,0,(0,0,0,0)",
                     ifc.out_valid, ifc.busy, ifc.in_ready, ifc.x0, ifc.x1, ifc.x2, ifc.x3);
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ifc.in_ready !== 1'b1 || ifc.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle rdy=%0b busy=%0b required 1,0", ifc.in_ready, ifc.busy);
        end
        issue(16'd1000, 1, 5'd8, 5'd14, 5'd12, 5'd10);
        drain();

        // Back-to-back sweep against the arithmetic reference.
        for (int i = 0; i < 30; i++) begin
            int prev;
            prev = last_acc;
            if (i == 0)       n = 16'd0;
            else if (i == 29) n = 16'hFFFF;
            else              n = 16'($urandom);
            issue(n, 1, 5'(n % 32), 5'(n % 17), 5'(n % 13), 5'(n % 11));
            if (i > 0) begin
                n_cmp++;
                if (last_acc - prev != 18) begin
                    n_bad++;
                    $display("FAIL issue_interval got=%0d required=18", last_acc - prev);
                end
            end
        end
        drain();

        // Reduced configuration: three channels, 12-bit operand.
        for (int k = 0; k < 2; k++) begin
            logic [11:0] n2;
            logic [2:0]  r0, r1, r2;
            n2 = (k == 0) ? 12'd4095 : 12'd100;
            r0 = (k == 0) ? 3'd7 : 3'd4;
            r1 = (k == 0) ? 3'd0 : 3'd2;
            r2 = 3'd0;
            @(negedge clk);
            ifc2.in_valid = 1'b1;
            ifc2.N = n2;
            @(posedge clk); #1;
            ifc2.in_valid = 1'b0;
            acc2 = cyc;
            waited = 0;
            @(negedge clk);
            while (!ifc2.out_valid && waited < 40) begin
                @(negedge clk);
                waited++;
            end
            n_cmp++;
            if (ifc2.out_valid !== 1'b1 || cyc - acc2 != 12) begin
                n_bad++;
                $display("FAIL small_latency N=%0d v=%0b got=%0d required=12", n2, ifc2.out_valid, cyc - acc2);
            end
            n_cmp++;
            if (ifc2.x0 !== r0 || ifc2.x1 !== r1 || ifc2.x2 !== r2 || ifc2.x3 !== 3'd0) begin
                n_bad++;
                $display("FAIL small_residues N=%0d got=(%0d,%0d,%0d,%0d) required=(%0d,%0d,%0d,0)",
                         n2, ifc2.x0, ifc2.x1, ifc2.x2, ifc2.x3, r0, r1, r2);
            end
            $display("txn small N=%0d residues=(%0d,%0d,%0d,%0d)", n2, ifc2.x0, ifc2.x1, ifc2.x2, ifc2.x3);
            @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
